// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Purpose  : Shared pipeline control types, state encoding and defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int unsigned c_default_timeout = 16;
    localparam int unsigned c_default_cnt_w   = 16;
    localparam int unsigned c_wait_cnt_w      = 8;

    typedef struct packed {
        logic freeze_if;
        logic freeze_id;
        logic flush_id;
        logic flush_exe;
        logic freeze_back;
    } ctrl_t;

    // Priority: memory stall, then taken branch, then ID hazard.
    function automatic ctrl_t f_decode(input logic mem_stall,
                                       input logic branch_taken,
                                       input logic hazard);
        ctrl_t c;
        c = '0;
        if (mem_stall) begin
            c.freeze_if   = 1'b1;
            c.freeze_id   = 1'b1;
            c.freeze_back = 1'b1;
        end else if (branch_taken) begin
            c.flush_id  = 1'b1;
            c.flush_exe = 1'b1;
        end else if (hazard) begin
            c.freeze_if = 1'b1;
            c.freeze_id = 1'b1;
            c.flush_exe = 1'b1;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Hazard/branch/memory status in, pipeline freeze/flush/stats out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = c_default_cnt_w
);
    logic             hazard;
    logic             branch_taken;
    logic             mem_access;
    logic             mem_ready;
    logic             freeze_if;
    logic             freeze_id;
    logic             flush_id;
    logic             flush_exe;
    logic             freeze_back;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hazard, branch_taken, mem_access, mem_ready,
        input  freeze_if, freeze_id, flush_id, flush_exe, freeze_back,
        input  mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  hazard, branch_taken, mem_access, mem_ready,
        output freeze_if, freeze_id, flush_id, flush_exe, freeze_back,
        output mem_err, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Width-parameterised counter with enable that holds at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Pipeline freeze/flush control with memory-wait timeout and stats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_default_timeout,
    // Must match the CNT_W of the connected interface instance.
    parameter int unsigned CNT_W   = c_default_cnt_w
) (
    input  wire logic clk,
    input  wire logic rst,
    pipeline_ctrl_if.slave pif
);
    localparam logic [c_wait_cnt_w-1:0] c_timeout_m1 = c_wait_cnt_w'(TIMEOUT - 1);

    state_e                  state_q;
    logic [c_wait_cnt_w-1:0] wait_cnt_q;
    logic                    mem_err_q;
    logic                    mem_stall_w;
    ctrl_t                   ctrl_w;
    logic                    stall_en_w;
    logic                    flush_en_w;

    assign mem_stall_w = pif.mem_access & ~pif.mem_ready;

    // Outputs are forced low while reset is held, whatever the inputs do.
    always_comb begin
        ctrl_w = '0;
        if (!rst) begin
            ctrl_w = f_decode(mem_stall_w, pif.branch_taken, pif.hazard);
        end
    end

    assign stall_en_w = ctrl_w.freeze_if;
    assign flush_en_w = ctrl_w.flush_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall_w) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall_w) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == c_timeout_m1) begin
                        // Counter parks at the limit; stalling carries on.
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_en_w),
        .cnt_o (pif.stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (flush_en_w),
        .cnt_o (pif.flush_cnt)
    );

    assign pif.freeze_if   = ctrl_w.freeze_if;
    assign pif.freeze_id   = ctrl_w.freeze_id;
    assign pif.flush_id    = ctrl_w.flush_id;
    assign pif.flush_exe   = ctrl_w.flush_exe;
    assign pif.freeze_back = ctrl_w.freeze_back;
    assign pif.mem_err     = mem_err_q;
endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed + random bench for two pipeline_ctrl configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(16)) ifa ();
    pipeline_ctrl_if #(.CNT_W(4))  ifb ();

    pipeline_ctrl #(.TIMEOUT(16), .CNT_W(16)) u_dut_a (.clk(clk), .rst(rst), .pif(ifa.slave));
    pipeline_ctrl #(.TIMEOUT(5),  .CNT_W(4))  u_dut_b (.clk(clk), .rst(rst), .pif(ifb.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = default config, 1 = TIMEOUT 5 / 4-bit counters.
    int unsigned m_to  [2] = '{16, 5};
    int unsigned m_max [2] = '{65535, 15};
    int unsigned m_run [2];
    int unsigned m_sc  [2];
    int unsigned m_fc  [2];
    logic        m_err [2];
    logic h, b, ma, mr;

    task automatic drive(input logic hh, input logic bb, input logic mma, input logic mmr);
        h = hh; b = bb; ma = mma; mr = mmr;
        ifa.hazard = hh; ifa.branch_taken = bb; ifa.mem_access = mma; ifa.mem_ready = mmr;
        ifb.hazard = hh; ifb.branch_taken = bb; ifb.mem_access = mma; ifb.mem_ready = mmr;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {freeze_if, freeze_id, flush_id, flush_exe, freeze_back}
    function automatic logic [4:0] exp_ctrl();
        if (rst)          return 5'b00000;
        if (ma && !mr)    return 5'b11001;
        if (b)            return 5'b00110;
        if (h)            return 5'b11010;
        return 5'b00000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_err[i] = 1'b0;
        end
    endtask

    // Timeout fires at the edge closing the (TIMEOUT+1)th consecutive stall cycle.
    task automatic model_edge();
        logic stall;
        stall = ma & ~mr;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (stall) begin
                    if (m_run[i] < 1000) m_run[i]++;
                    if (m_run[i] >= m_to[i] + 1) m_err[i] = 1'b1;
                end else begin
                    m_run[i] = 0;
                end
                if ((stall || (h && !b)) && m_sc[i] < m_max[i]) m_sc[i]++;
                if ((b && !stall) && m_fc[i] < m_max[i]) m_fc[i]++;
            end
        end
    endtask

    task automatic check_comb(input string tag);
        chk({tag, " a.ctrl"}, 32'({ifa.freeze_if, ifa.freeze_id, ifa.flush_id,
                                  ifa.flush_exe, ifa.freeze_back}), 32'(exp_ctrl()));
        chk({tag, " b.ctrl"}, 32'({ifb.freeze_if, ifb.freeze_id, ifb.flush_id,
                                  ifb.flush_exe, ifb.freeze_back}), 32'(exp_ctrl()));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " a.mem_err"},   32'(ifa.mem_err),   32'(m_err[0]));
        chk({tag, " a.stall_cnt"}, 32'(ifa.stall_cnt), m_sc[0]);
        chk({tag, " a.flush_cnt"}, 32'(ifa.flush_cnt), m_fc[0]);
        chk({tag, " b.mem_err"},   32'(ifb.mem_err),   32'(m_err[1]));
        chk({tag, " b.stall_cnt"}, 32'(ifb.stall_cnt), m_sc[1]);
        chk({tag, " b.flush_cnt"}, 32'(ifb.flush_cnt), m_fc[1]);
    endtask

    // Inputs are set shortly after a rising edge; outputs checked before and after the next edge.
    task automatic cycle(input string tag);
        #1;
        check_comb(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_comb({tag, " in-rst"});
        check_regs({tag, " in-rst"});
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        model_reset();
        #2;
        check_comb("reset all-ones inputs");
        check_regs("reset");
        cycle("reset held");
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) cycle("idle");
        chk("idle a.stall_cnt", 32'(ifa.stall_cnt), 32'd0);

        do_reset("pre-hazard");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("hazard");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("hazard done");
        chk("hazard a.stall_cnt==1", 32'(ifa.stall_cnt), 32'd1);

        do_reset("pre-branch");
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cycle("branch+hazard");
        chk("branch a.flush_cnt==1", 32'(ifa.flush_cnt), 32'd1);
        chk("branch a.stall_cnt==0", 32'(ifa.stall_cnt), 32'd0);

        do_reset("pre-memwait");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            cycle("mem stall w/ branch");
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle("mem ready w/ branch");
        chk("memwait a.stall_cnt==3", 32'(ifa.stall_cnt), 32'd3);
        chk("memwait a.flush_cnt==1", 32'(ifa.flush_cnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("memwait idle");

        do_reset("pre-ready-same-cycle");
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        cycle("access+ready same cycle");
        chk("no stall a.stall_cnt==0", 32'(ifa.stall_cnt), 32'd0);

        do_reset("pre-timeout");
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            cycle("timeout build");
        end
        chk("timeout a.mem_err not yet", 32'(ifa.mem_err), 32'd0);
        cycle("timeout edge");
        chk("timeout a.mem_err set", 32'(ifa.mem_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle("timeout still stalling");
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        cycle("timeout ready");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("timeout sticky");
        chk("timeout a.mem_err sticky", 32'(ifa.mem_err), 32'd1);
        do_reset("timeout clear");
        chk("timeout a.mem_err cleared", 32'(ifa.mem_err), 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            cycle("hazard saturate");
        end
        chk("saturate b.stall_cnt==15", 32'(ifb.stall_cnt), 32'd15);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        do_reset("pre-async");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            cycle("async wait");
        end
        rst = 1'b1;
        model_reset();
        #1;
        check_comb("async rst mid-wait");
        check_regs("async rst mid-wait");
        cycle("async rst held");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle("post-async stall");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("post-async idle");

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                do_reset("random reset");
            end
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0));
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the MEM_WAIT cycles before a memory timeout is flagged (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the performance counter width.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 hazard  in  1  data/load-use hazard flag from the hazard unit, for the instruction currently in ID.
REQ-006 branch_taken  in  1  taken branch resolved in EXE.
REQ-007 mem_access  in  1  MEM stage holds a load or store.
REQ-008 mem_ready  in  1  SRAM controller completes the access this cycle.
REQ-009 freeze_if  out  1  hold PC and the IF/ID register.
REQ-010 freeze_id  out  1  hold the ID/EXE register.
REQ-011 flush_id  out  1  clear the IF/ID register (pc := 0 / NOP).
REQ-012 flush_exe  out  1  clear the ID/EXE register (inject bubble).
REQ-013 freeze_back  out  1  hold the EXE/MEM and MEM/WB registers.
REQ-014 mem_err  out  1  sticky memory-timeout flag.
REQ-015 stall_cnt  out  CNT_W  saturating count of stall cycles.
REQ-016 flush_cnt  out  CNT_W  saturating count of branch flushes.

Function
REQ-017 The FSM SHALL have states RUN and MEM_WAIT.
REQ-018 RUN SHALL go to MEM_WAIT when mem_access & ~mem_ready; otherwise it SHALL stay in RUN.
REQ-019 MEM_WAIT SHALL return to RUN on mem_ready, and also on ~mem_access (access withdrawn).
REQ-020 mem_stall SHALL be mem_access & ~mem_ready, in either state, combinational.
REQ-021 All freeze/flush outputs SHALL be combinational from the current inputs, with zero-cycle latency, so that the pipeline registers sample them at the same edge.
REQ-022 Priority SHALL be mem_stall > branch_taken > hazard.
REQ-023 On mem_stall:
- freeze_if = freeze_id = freeze_back = 1.
- flush_id = flush_exe = 0.
- branch_taken and hazard are ignored this cycle; they persist because the pipeline is frozen.
REQ-024 On branch_taken without mem_stall:
- flush_id = flush_exe = 1.
- all freezes = 0, so the PC loads the branch target.
REQ-025 On hazard without mem_stall or branch_taken:
- freeze_if = freeze_id = 1 and flush_exe = 1 (bubble).
- freeze_back = 0.
REQ-026 With no condition active, all five control outputs SHALL be 0.
REQ-027 wait_cnt (8-bit) SHALL clear on entry to MEM_WAIT and increment each cycle spent in MEM_WAIT.
REQ-028 When wait_cnt reaches TIMEOUT-1 with mem_stall still active, mem_err SHALL set on that edge and stay set until reset.
REQ-029 A timeout SHALL NOT change the stalling behaviour; the block remains in MEM_WAIT.
REQ-030 stall_cnt SHALL increment on every cycle where mem_stall or a REQ-025 hazard stall is active, and SHALL hold at all-ones.
REQ-031 flush_cnt SHALL increment on every cycle with a REQ-024 flush, and SHALL hold at all-ones.
REQ-032 mem_ready asserted in the same cycle that mem_access rises SHALL produce no stall and no MEM_WAIT entry.

Reset
REQ-033 While rst is high:
- state = RUN, wait_cnt = 0, mem_err = 0, stall_cnt = 0, flush_cnt = 0.
- All control outputs SHALL be 0, irrespective of the other inputs.
REQ-034 Reset asserted mid-MEM_WAIT SHALL abandon the wait immediately, with no timeout flagged.

Structure
REQ-035 The state encoding (RUN=0, MEM_WAIT=1) and the default TIMEOUT SHALL live in the shared pipeline package.
REQ-036 The block SHALL instantiate one sub-module, sat_counter (width-parameterised saturating counter with enable), twice: once for stall_cnt and once for flush_cnt.

Verification
REQ-037 Reset released, all inputs 0 for 5 cycles -> all outputs 0, counters 0.
REQ-038 hazard=1 for 1 cycle -> freeze_if=1, freeze_id=1, flush_exe=1, flush_id=0 in that cycle; stall_cnt=1 afterwards.
REQ-039 branch_taken=1 and hazard=1 together -> flush_id=1, flush_exe=1, freezes 0; flush_cnt=1, stall_cnt=0.
REQ-040 mem_access=1, mem_ready low for 3 cycles then high, with branch_taken=1 throughout -> freeze_back=1 for 3 cycles; then flush_id=1 in the ready cycle; stall_cnt=3, flush_cnt=1.
REQ-041 TIMEOUT=16, mem_access=1, mem_ready=0 held -> mem_err rises after the 16th MEM_WAIT edge; it stays 1 after mem_ready, and clears only on rst.
REQ-042 CNT_W=4, hazard held 20 cycles -> stall_cnt saturates at 15.
